// File: rtl/lsu_ctrl_pkg.sv
// LSU controller shared definitions:
// rw_type bit indices, FSM encoding, strobes.
package lsu_ctrl_pkg;

  localparam int RW_U = 3;
  localparam int RW_W = 2;
  localparam int RW_H = 1;
  localparam int RW_B = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  // No size bit set falls back to a word access.
  function automatic size_t size_of(input logic [3:0] rw);
    size_t s;
    s = SZ_W;
    if (rw[RW_B])      s = SZ_B;
    else if (rw[RW_H]) s = SZ_H;
    else if (rw[RW_W]) s = SZ_W;
    return s;
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Byte-lane steering: store replication/strobes
// and load lane extract with sign/zero extension.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  size_t       i_size,
  input  logic        i_sign,
  input  logic [1:0]  i_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_strb,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_rdata[{i_lo, 3'b000} +: 8];
    w_half  = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_wdata = i_wdata;
    o_strb  = STRB_W;
    o_ldata = i_rdata;
    unique case (i_size)
      SZ_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_strb  = STRB_B << i_lo;
        o_ldata = {{24{i_sign & w_byte[7]}}, w_byte};
      end
      SZ_H: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_strb  = STRB_H << {i_lo[1], 1'b0};
        o_ldata = {{16{i_sign & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one bus access per
// memory op, pipeline stall until completion.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [3:0]        rw_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [4:0]        rd_in,
  output logic              stall,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_strb,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic              done,
  output logic              ld_wen,
  output logic [4:0]        ld_rd,
  output logic [31:0]       ld_data,
  output logic              misalign
);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_lo;
  size_t             r_size;
  logic              r_sign, r_we, r_mis;
  logic [4:0]        r_rd;
  logic [31:0]       r_wdata, r_ld;
  logic [3:0]        r_strb;

  logic        w_idle, w_op, w_mis, w_acc;
  size_t       w_size, w_sel_size;
  logic [1:0]  w_sel_lo;
  logic [31:0] w_al_wdata, w_al_ldata;
  logic [3:0]  w_al_strb;

  assign w_idle = (r_state == S_IDLE);
  assign w_op   = req_valid & (mem_ren | mem_wen);
  assign w_size = size_of(rw_type);
  assign w_mis  = ((w_size == SZ_H) && addr[0]) ||
                  ((w_size == SZ_W) && (addr[1:0] != 2'b00));
  assign w_acc  = w_idle & w_op & ~w_mis;

  // Store lanes come from live inputs; load lanes from the capture.
  assign w_sel_size = w_idle ? w_size : r_size;
  assign w_sel_lo   = w_idle ? addr[1:0] : r_lo;

  lsu_align u_align (
    .i_size  (w_sel_size),
    .i_sign  (r_sign),
    .i_lo    (w_sel_lo),
    .i_wdata (wdata),
    .i_rdata (bus_rdata),
    .o_wdata (w_al_wdata),
    .o_strb  (w_al_strb),
    .o_ldata (w_al_ldata)
  );

  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    bus_valid = 1'b0;
    done      = 1'b0;
    ld_wen    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_next = S_REQ;
          stall  = 1'b1;
        end
      end
      S_REQ: begin
        stall     = 1'b1;
        bus_valid = 1'b1;
        if (bus_ready) w_next = r_we ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        ld_wen = ~r_we;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_lo    <= 2'b00;
      r_size  <= SZ_W;
      r_sign  <= 1'b0;
      r_we    <= 1'b0;
      r_rd    <= 5'd0;
      r_wdata <= 32'd0;
      r_strb  <= STRB_NONE;
      r_ld    <= 32'd0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mis   <= w_idle & w_op & w_mis;
      if (w_acc) begin
        r_addr  <= {addr[ADDR_W-1:2], 2'b00};
        r_lo    <= addr[1:0];
        r_size  <= w_size;
        r_sign  <= ~rw_type[RW_U];
        r_we    <= mem_wen;
        r_rd    <= rd_in;
        r_wdata <= mem_wen ? w_al_wdata : 32'd0;
        r_strb  <= mem_wen ? w_al_strb : STRB_NONE;
      end
      if ((r_state == S_WAIT) && bus_rvalid)
        r_ld <= w_al_ldata;
    end
  end

  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_strb  = r_strb;
  assign ld_rd     = r_rd;
  assign ld_data   = r_ld;
  assign misalign  = r_mis;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases
// plus randomized ops against a transaction model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, mem_ren, mem_wen;
  logic [3:0]  rw_type;
  logic [31:0] addr, wdata;
  logic [4:0]  rd_in;
  logic        stall, bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_strb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        done, ld_wen;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        misalign;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .rw_type(rw_type),
    .addr(addr), .wdata(wdata), .rd_in(rd_in),
    .stall(stall), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_strb(bus_strb), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .done(done),
    .ld_wen(ld_wen), .ld_rd(ld_rd),
    .ld_data(ld_data), .misalign(misalign)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Access size in bytes from the one-hot size bits.
  function automatic int nbytes(input logic [3:0] rw);
    if (rw[0]) return 1;
    if (rw[1]) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] lane_mask(input int n);
    return (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
  endfunction

  function automatic logic [3:0] m_strb(input logic [3:0] rw,
                                        input logic [31:0] a);
    int n = nbytes(rw);
    int s = ((1 << n) - 1) << (a % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] rw,
                                          input logic [31:0] wd);
    int n = nbytes(rw);
    logic [31:0] lane = wd & lane_mask(n);
    logic [31:0] r = 32'd0;
    for (int k = 0; k < 4 / n; k++) r = r | (lane << (8 * n * k));
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] rw,
                                         input logic [31:0] a,
                                         input logic [31:0] rdat);
    int n = nbytes(rw);
    logic [31:0] m = lane_mask(n);
    logic [31:0] v = (rdat >> (8 * (a % 4))) & m;
    if (n < 4 && !rw[3] && v[8 * n - 1]) v = v | ~m;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_op();
    req_valid = 1'($urandom_range(0, 1));
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    rw_type   = 4'($urandom);
    addr      = $urandom;
    wdata     = $urandom;
    rd_in     = 5'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".stall"}, stall, 0);
    check({tag, ".bvalid"}, bus_valid, 0);
    check({tag, ".bwe"}, bus_we, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".ldwen"}, ld_wen, 0);
    check({tag, ".mis"}, misalign, 0);
    check({tag, ".strb"}, bus_strb, 0);
    check({tag, ".lddata"}, ld_data, 0);
    check({tag, ".ldrd"}, ld_rd, 0);
    check({tag, ".baddr"}, bus_addr, 0);
    check({tag, ".bwdata"}, bus_wdata, 0);
  endtask

  // One memory op from the EX cycle through completion.
  task automatic run_op(input string tag, input logic we,
                        input logic [3:0] rw, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input int rdy, input int rvd,
                        input logic [31:0] rdat, input logic hold);
    int n = nbytes(rw);
    logic mis = (a % n) != 0;
    req_valid  = 1'b1;
    mem_wen    = we;
    mem_ren    = we ? 1'($urandom_range(0, 1)) : 1'b1;
    rw_type    = rw;
    addr       = a;
    wdata      = wd;
    rd_in      = rd;
    bus_ready  = 1'($urandom_range(0, 1));
    bus_rvalid = 1'($urandom_range(0, 1));
    @(negedge clk);
    check({tag, ".op_stall"}, stall, 64'(!mis));
    check({tag, ".op_bvalid"}, bus_valid, 0);
    check({tag, ".op_done"}, done, 0);
    tick();
    if (mis) begin
      drop_op();
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      @(negedge clk);
      check({tag, ".mis"}, misalign, 1);
      check({tag, ".mis_bvalid"}, bus_valid, 0);
      check({tag, ".mis_stall"}, stall, 0);
      check({tag, ".mis_ldwen"}, ld_wen, 0);
      tick();
      return;
    end
    if (!hold) drop_op();
    for (int i = 0; i <= rdy; i++) begin
      bus_ready  = (i == rdy);
      bus_rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, ".req_bvalid"}, bus_valid, 1);
      check({tag, ".req_stall"}, stall, 1);
      check({tag, ".baddr"}, bus_addr, a & 32'hFFFF_FFFC);
      check({tag, ".bwe"}, bus_we, we);
      check({tag, ".strb"}, bus_strb, we ? m_strb(rw, a) : 4'd0);
      if (we) check({tag, ".bwdata"}, bus_wdata, m_wdata(rw, wd));
      tick();
      if (!hold) drop_op();
    end
    bus_ready = 1'b0;
    if (!we) begin
      for (int i = 0; i <= rvd; i++) begin
        bus_rvalid = (i == rvd);
        bus_rdata  = (i == rvd) ? rdat : $urandom;
        bus_ready  = 1'($urandom_range(0, 1));
        @(negedge clk);
        check({tag, ".wait_bvalid"}, bus_valid, 0);
        check({tag, ".wait_stall"}, stall, 1);
        tick();
        if (!hold) drop_op();
      end
    end
    bus_rvalid = 1'($urandom_range(0, 1));
    bus_ready  = 1'($urandom_range(0, 1));
    bus_rdata  = $urandom;
    @(negedge clk);
    check({tag, ".done"}, done, 1);
    check({tag, ".done_stall"}, stall, 0);
    check({tag, ".done_bvalid"}, bus_valid, 0);
    check({tag, ".ldwen"}, ld_wen, 64'(!we));
    if (!we) begin
      check({tag, ".ldrd"}, ld_rd, rd);
      check({tag, ".lddata"}, ld_data, m_load(rw, a, rdat));
    end
    tick();
    drop_op();
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  logic [3:0] rw_r;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    rw_type    = 4'd0;
    addr       = 32'd0;
    wdata      = 32'd0;
    rd_in      = 5'd0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_vals("reset");
    tick();
    rst = 1'b0;

    run_op("sw", 1, 4'b0100, 32'h100, 32'hDEAD_BEEF, 5'd0,
           0, 0, 32'd0, 0);
    run_op("lb", 0, 4'b0001, 32'h103, 32'd0, 5'd7,
           0, 1, 32'h80FF_FF7F, 0);
    run_op("lbu", 0, 4'b1001, 32'h103, 32'd0, 5'd11,
           0, 0, 32'h80FF_FF7F, 0);
    run_op("sh", 1, 4'b0010, 32'h102, 32'h1234_ABCD, 5'd0,
           4, 0, 32'd0, 0);
    run_op("lw_mis", 0, 4'b0100, 32'h101, 32'd0, 5'd3,
           0, 0, 32'd0, 0);
    run_op("sw_none", 1, 4'b0000, 32'h200, 32'hCAFE_F00D, 5'd0,
           1, 0, 32'd0, 0);
    run_op("lhu", 0, 4'b1010, 32'h302, 32'd0, 5'd31,
           2, 3, 32'h8001_7FFF, 0);

    // Abandon a load in WAIT; the late rvalid must be ignored.
    req_valid = 1'b1;
    mem_ren   = 1'b1;
    mem_wen   = 1'b0;
    rw_type   = 4'b0100;
    addr      = 32'h300;
    rd_in     = 5'd9;
    @(negedge clk);
    check("rst_mid.op_stall", stall, 1);
    tick();
    drop_op();
    bus_ready = 1'b1;
    @(negedge clk);
    check("rst_mid.req_bvalid", bus_valid, 1);
    tick();
    bus_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("rst_mid.wait_stall", stall, 1);
    tick();
    rst        = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = $urandom;
    @(negedge clk);
    check_reset_vals("rst_mid");
    tick();
    bus_rvalid = 1'b0;
    @(negedge clk);
    check("rst_mid.late_done", done, 0);
    check("rst_mid.late_ldwen", ld_wen, 0);
    tick();
    run_op("after_rst", 0, 4'b0100, 32'h400, 32'd0, 5'd4,
           0, 0, 32'h1357_9BDF, 0);

    run_op("b2b_st", 1, 4'b0001, 32'h501, 32'h0000_00A5, 5'd0,
           0, 0, 32'd0, 1);
    run_op("b2b_ld", 0, 4'b0010, 32'h502, 32'd0, 5'd12,
           1, 0, 32'hBEEF_0000, 1);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0:       rw_r = 4'b0001;
        1:       rw_r = 4'b0010;
        2:       rw_r = 4'b0100;
        default: rw_r = 4'b0000;
      endcase
      rw_r[3] = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)),
             rw_r, $urandom, $urandom, 5'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
